// File: rtl/cpu_pkg.sv
// cpu_pkg: shared fetch-side constants and types.
// Imported by ifetch_buf and ifetch_unit.
package cpu_pkg;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;

   localparam int BUF_DEPTH = 2;
   localparam int BUF_AW    = $clog2(BUF_DEPTH);
   localparam int BUF_CW    = $clog2(BUF_DEPTH + 1);

   typedef logic [BUF_CW-1:0] buf_cnt_t;

   typedef enum logic [1:0] {
      IF_IDLE,
      IF_REQ,
      IF_ADV,
      IF_DROP
   } ifetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
   } fetch_ent_t;

endpackage

// File: rtl/ifetch_buf.sv
// ifetch_buf: small FIFO of fetched {pc, insn} pairs.
// Head is combinational; clear wins over push and pop.
module ifetch_buf
   import cpu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       push,
   input  fetch_ent_t push_ent,
   input  logic       pop,
   input  logic       clear,
   output buf_cnt_t   count,
   output fetch_ent_t head
);

   fetch_ent_t        mem_q [BUF_DEPTH];
   fetch_ent_t        mem_d [BUF_DEPTH];
   logic [BUF_AW-1:0] wr_q, wr_d;
   logic [BUF_AW-1:0] rd_q, rd_d;
   buf_cnt_t          cnt_q, cnt_d;
   logic              do_pop;

   always_comb begin
      mem_d  = mem_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      cnt_d  = cnt_q;
      do_pop = pop && (cnt_q != '0);
      if (clear) begin
         wr_d  = '0;
         rd_d  = '0;
         cnt_d = '0;
      end else begin
         if (push) begin
            mem_d[wr_q] = push_ent;
            wr_d        = wr_q + BUF_AW'(1);
         end
         if (do_pop) begin
            rd_d = rd_q + BUF_AW'(1);
         end
         cnt_d = cnt_q + buf_cnt_t'(push) - buf_cnt_t'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         mem_q <= mem_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign count = cnt_q;
   assign head  = mem_q[rd_q];

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: one-request-at-a-time fetch FSM feeding a 2-deep buffer.
// Define IFETCH_ALIGN_CHECK_EN to add the sticky fetch_err alignment check.
module ifetch_unit
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PC,
   output logic        PCWriteEn,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        ir_valid,
   output logic [31:0] ir,
   output logic [31:0] ir_pc,
   input  logic        ir_ready
`ifdef IFETCH_ALIGN_CHECK_EN
   ,
   output logic        fetch_err
`endif
);

   ifetch_state_e state_q, state_d;
   logic          req_q, req_d;
   logic [31:0]   addr_q, addr_d;
   logic          push;
   logic          start;
   logic          room;
   logic          pop;
   buf_cnt_t      buf_cnt;
   fetch_ent_t    head;

   // Nothing is outstanding in IDLE, so room depends on the buffer alone.
   assign room = buf_cnt < buf_cnt_t'(BUF_DEPTH);

`ifdef IFETCH_ALIGN_CHECK_EN
   logic err_q, err_d;
`else
   logic unused_pc_lo;
   assign unused_pc_lo = ^PC[1:0];
`endif

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      addr_d  = addr_q;
      push    = 1'b0;
      start   = !flush && room;
`ifdef IFETCH_ALIGN_CHECK_EN
      err_d = err_q;
      if (flush) begin
         err_d = 1'b0;
      end else if (state_q == IF_IDLE && PC[1:0] != 2'b00) begin
         err_d = 1'b1;
      end
      start = start && !err_q && (PC[1:0] == 2'b00);
`endif
      unique case (state_q)
         IF_IDLE: begin
            if (start) begin
               state_d = IF_REQ;
               req_d   = 1'b1;
               addr_d  = {PC[31:2], 2'b00};
            end
         end
         IF_REQ: begin
            if (imem_ack) begin
               req_d = 1'b0;
               if (flush) begin
                  state_d = IF_IDLE;
               end else begin
                  push    = 1'b1;
                  state_d = IF_ADV;
               end
            end else if (flush) begin
               state_d = IF_DROP;
            end
         end
         IF_ADV: begin
            state_d = IF_IDLE;
         end
         IF_DROP: begin
            if (imem_ack) begin
               req_d   = 1'b0;
               state_d = IF_IDLE;
            end
         end
         default: begin
            state_d = IF_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IF_IDLE;
         req_q   <= 1'b0;
         addr_q  <= RESET_PC;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
      end
   end

`ifdef IFETCH_ALIGN_CHECK_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign fetch_err = err_q;
`endif

   assign pop = ir_valid && ir_ready;

   ifetch_buf u_buf (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .push_ent ('{pc: addr_q, insn: imem_rdata}),
      .pop      (pop),
      .clear    (flush),
      .count    (buf_cnt),
      .head     (head)
   );

   assign PCWriteEn = (state_q == IF_ADV) && !flush;
   assign imem_req  = req_q;
   assign imem_addr = addr_q;
   assign ir_valid  = buf_cnt != '0;
   assign ir        = head.insn;
   assign ir_pc     = head.pc;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: scoreboard bench with a latency-programmable memory.
// Build with +define+IFETCH_ALIGN_CHECK_EN to cover fetch_err.
`timescale 1ns/1ps
module tb_ifetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] PC = 32'h0000_3000;
   logic        PCWriteEn;
   logic        flush = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        ir_valid;
   logic [31:0] ir;
   logic [31:0] ir_pc;
   logic        ir_ready = 1'b0;
`ifdef IFETCH_ALIGN_CHECK_EN
   logic        fetch_err;
`endif

   always #5 clk = ~clk;

   ifetch_unit dut (
      .clk        (clk),
      .rst        (rst),
      .PC         (PC),
      .PCWriteEn  (PCWriteEn),
      .flush      (flush),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .ir_valid   (ir_valid),
      .ir         (ir),
      .ir_pc      (ir_pc),
      .ir_ready   (ir_ready)
`ifdef IFETCH_ALIGN_CHECK_EN
      ,
      .fetch_err  (fetch_err)
`endif
   );

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] insn;
   } exp_t;

   typedef struct {
      int lat;
      int steps;
      int exp_pulses;
   } vec_t;

   exp_t        sbq[$];
   logic [31:0] popped[$];
   int          total = 0;
   int          bad = 0;
   int          lat;
   bit          ready_cfg;
   bit          flush_req;
   bit          flush_when_ack;
   logic [31:0] flush_tgt;
   logic [31:0] pc_m;
   bit          adv_m;
   bit          drop_m;
   int          wait_cnt;
   int          pulses;
   int          pops;
   int          issues;
   bit          req_prev;
   vec_t        vt[7];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_3000) return 32'h8C01_0004;
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_clear(input logic [31:0] start_pc);
      sbq.delete();
      popped.delete();
      pc_m      = start_pc;
      PC        = start_pc;
      adv_m     = 1'b0;
      drop_m    = 1'b0;
      wait_cnt  = 0;
      req_prev  = 1'b0;
      pulses    = 0;
      pops      = 0;
      issues    = 0;
      flush_req = 1'b0;
      flush_when_ack = 1'b0;
      flush     = 1'b0;
      imem_ack  = 1'b0;
      imem_rdata = '0;
      ir_ready  = 1'b0;
   endtask

   task automatic do_reset(input logic [31:0] start_pc);
      rst = 1'b0;
      model_clear(start_pc);
      repeat (2) @(negedge clk);
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_imem_addr", imem_addr, 32'h0000_3000);
      chk("rst_ir_valid", 32'(ir_valid), 32'd0);
      chk("rst_ir", ir, 32'd0);
      chk("rst_ir_pc", ir_pc, 32'd0);
      chk("rst_pcwe", 32'(PCWriteEn), 32'd0);
`ifdef IFETCH_ALIGN_CHECK_EN
      chk("rst_fetch_err", 32'(fetch_err), 32'd0);
`endif
      rst = 1'b1;
   endtask

   // One clock: check outputs, answer the memory, drive inputs, update model.
   task automatic step();
      bit          ack;
      bit          fl;
      bit          pushed;
      bit          req_now;
      logic [31:0] rd;
      @(negedge clk);
      chk("ir_valid", 32'(ir_valid), 32'(sbq.size() != 0));
      if (sbq.size() != 0) begin
         chk("ir", ir, sbq[0].insn);
         chk("ir_pc", ir_pc, sbq[0].pc);
      end
      req_now = imem_req;
      ack = 1'b0;
      rd  = '0;
      if (req_now) begin
         if (wait_cnt >= lat) begin
            ack      = 1'b1;
            wait_cnt = 0;
            rd = drop_m ? 32'hDEAD_BEEF : mem_word(imem_addr);
            if (!drop_m) chk("imem_addr", imem_addr, pc_m);
         end else begin
            wait_cnt++;
         end
      end else begin
         wait_cnt = 0;
      end
      fl = flush_req || (flush_when_ack && ack);
      imem_ack   = ack;
      imem_rdata = rd;
      flush      = fl;
      ir_ready   = ready_cfg;
      #1;
      chk("PCWriteEn", 32'(PCWriteEn), 32'(adv_m && !fl));
      if (PCWriteEn) pulses++;
      if (ir_valid && ir_ready) begin
         pops++;
         popped.push_back(ir_pc);
      end
      if (req_now && !req_prev) issues++;
      req_prev = req_now;
      if (ready_cfg && sbq.size() != 0) void'(sbq.pop_front());
      if (fl) sbq.delete();
      pushed = ack && !drop_m && !fl;
      if (pushed) sbq.push_back('{pc: pc_m, insn: mem_word(pc_m)});
      if (drop_m && ack) drop_m = 1'b0;
      else if (fl && req_now && !ack) drop_m = 1'b1;
      if (fl) pc_m = flush_tgt;
      else if (adv_m) pc_m = pc_m + 32'd4;
      adv_m = pushed;
      PC = pc_m;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{lat: 0, steps: 1,  exp_pulses: 0};
      vt[1] = '{lat: 0, steps: 2,  exp_pulses: 1};
      vt[2] = '{lat: 0, steps: 10, exp_pulses: 3};
      vt[3] = '{lat: 0, steps: 11, exp_pulses: 4};
      vt[4] = '{lat: 1, steps: 10, exp_pulses: 2};
      vt[5] = '{lat: 1, steps: 11, exp_pulses: 3};
      vt[6] = '{lat: 2, steps: 14, exp_pulses: 3};
      flush_tgt = 32'h0000_3000;
      lat = 0;
      ready_cfg = 1'b0;
      #1;

      for (int v = 0; v < 7; v++) begin
         do_reset(32'h0000_3000);
         lat = vt[v].lat;
         ready_cfg = 1'b1;
         repeat (vt[v].steps) step();
         chk("vec_pulses", 32'(pulses), 32'(vt[v].exp_pulses));
         chk("vec_pops", 32'(pops), 32'(vt[v].exp_pulses));
      end

      // First fetch, two wait states, decode stalled.
      do_reset(32'h0000_3000);
      lat = 2;
      ready_cfg = 1'b0;
      repeat (4) step();
      chk("first_ir_valid", 32'(ir_valid), 32'd1);
      chk("first_ir", ir, 32'h8C01_0004);
      chk("first_ir_pc", ir_pc, 32'h0000_3000);
      step();
      chk("first_pulses", 32'(pulses), 32'd1);

      // Stalled decode fills exactly two entries, then drains in order.
      do_reset(32'h0000_3000);
      lat = 0;
      ready_cfg = 1'b0;
      repeat (20) step();
      chk("full_issues", 32'(issues), 32'd2);
      chk("full_req_idle", 32'(imem_req), 32'd0);
      chk("full_valid", 32'(ir_valid), 32'd1);
      chk("full_pulses", 32'(pulses), 32'd2);
      ready_cfg = 1'b1;
      repeat (2) step();
      chk("drain_count", 32'(popped.size()), 32'd2);
      if (popped.size() >= 2) begin
         chk("drain_pc0", popped[0], 32'h0000_3000);
         chk("drain_pc1", popped[1], 32'h0000_3004);
      end
      repeat (6) step();

      // Flush while waiting: the late data is dropped, redirect is used.
      do_reset(32'h0000_3000);
      lat = 3;
      ready_cfg = 1'b1;
      step();
      flush_req = 1'b1;
      flush_tgt = 32'h0000_3040;
      step();
      flush_req = 1'b0;
      for (int i = 0; i < 20 && issues < 2; i++) step();
      chk("drop_reissue", 32'(issues), 32'd2);
      chk("drop_new_addr", imem_addr, 32'h0000_3040);
      chk("drop_pulses", 32'(pulses), 32'd0);
      chk("drop_valid", 32'(ir_valid), 32'd0);
      repeat (8) step();

      // Flush coincident with ack.
      do_reset(32'h0000_3000);
      lat = 0;
      ready_cfg = 1'b1;
      flush_tgt = 32'h0000_3100;
      flush_when_ack = 1'b1;
      step();
      flush_when_ack = 1'b0;
      step();
      chk("fa_req", 32'(imem_req), 32'd0);
      chk("fa_pcwe", 32'(PCWriteEn), 32'd0);
      chk("fa_valid", 32'(ir_valid), 32'd0);
      step();
      chk("fa_idle_req", 32'(imem_req), 32'd1);
      chk("fa_idle_addr", imem_addr, 32'h0000_3100);
      repeat (4) step();

      // Flush empties a full buffer in one edge.
      do_reset(32'h0000_3000);
      lat = 0;
      ready_cfg = 1'b0;
      repeat (8) step();
      chk("fl_full", 32'(ir_valid), 32'd1);
      flush_req = 1'b1;
      flush_tgt = 32'h0000_3200;
      step();
      flush_req = 1'b0;
      step();
      chk("fl_empty", 32'(ir_valid), 32'd0);
      ready_cfg = 1'b1;
      repeat (6) step();

      // Reset mid-request, then a stray ack.
      do_reset(32'h0000_3000);
      lat = 5;
      ready_cfg = 1'b1;
      repeat (2) step();
      chk("mid_req_high", 32'(imem_req), 32'd1);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_req", 32'(imem_req), 32'd0);
      chk("async_addr", imem_addr, 32'h0000_3000);
      chk("async_valid", 32'(ir_valid), 32'd0);
      model_clear(32'h0000_3000);
      @(negedge clk);
      rst = 1'b1;
      imem_ack = 1'b1;
      imem_rdata = 32'h5555_AAAA;
      @(posedge clk);
      #1 imem_ack = 1'b0;
      chk("stray_valid", 32'(ir_valid), 32'd0);
      chk("stray_req", 32'(imem_req), 32'd1);
      lat = 0;
      repeat (4) step();

`ifdef IFETCH_ALIGN_CHECK_EN
      do_reset(32'h0000_3002);
      lat = 0;
      ready_cfg = 1'b1;
      repeat (3) step();
      chk("err_set", 32'(fetch_err), 32'd1);
      chk("err_no_req", 32'(imem_req), 32'd0);
      chk("err_issues", 32'(issues), 32'd0);
      flush_req = 1'b1;
      flush_tgt = 32'h0000_3000;
      step();
      flush_req = 1'b0;
      step();
      chk("err_clear", 32'(fetch_err), 32'd0);
      repeat (3) step();
      chk("err_resume", 32'(issues), 32'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
